// File: rtl/defines_pkg.sv
// Shared constants and types for the dataflow channel.
//   DEFAULT_WIDTH   default token data width
//   MAX_CW          count width for the largest legal depth (256)
//   chan_status_t   occupancy snapshot {count, max_count}
package defines_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned MAX_CW        = 9;

  typedef struct packed {
    logic [MAX_CW-1:0] count;
    logic [MAX_CW-1:0] max_count;
  } chan_status_t;

endpackage

// File: rtl/bdf_channel_mem.sv
// Token storage for bdf_channel: one write port, one asynchronous read port.
//   clk, rst   clock and synchronous active-low reset
//   we/waddr/wdata   write port
//   raddr/rdata      combinational read port
// Entries below INIT_TOKENS are cleared on reset so the delay tokens read as 0.
module bdf_channel_mem #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned INIT_TOKENS = 0,
  parameter int unsigned AW          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; reset clears only the preloaded entries.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i < INIT_TOKENS) mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bdf_channel.sv
// Bounded FIFO channel carrying tokens between two dataflow PEs.
//   clk, rst            clock, synchronous active-low reset
//   in_data/in_valid/in_ready     producer side
//   out_data/out_valid/out_ready  consumer side (first-word-fall-through)
//   count, max_count    current occupancy and high-water mark since reset
// The handshake flags are flops, so neither ready/valid depends on the
// opposite-side inputs in the same cycle.
module bdf_channel
  import defines_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned INIT_TOKENS = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH+1)-1:0]   max_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  // Illegal parameter combinations stop elaboration.
  if (INIT_TOKENS > DEPTH || DEPTH < 2) begin : g_param_check
    $error("bdf_channel: need DEPTH >= 2 and INIT_TOKENS <= DEPTH");
  end

  logic [AW-1:0] rd_ptr, rd_ptr_next;
  logic [AW-1:0] wr_ptr, wr_ptr_next;
  logic [CW-1:0] count_next, max_next;
  logic          in_ready_next, out_valid_next;
  logic          push, pop;

  // Both handshakes come from registered flags only.
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Next-state logic for pointers, occupancy and flags.
  always_comb begin
    rd_ptr_next    = rd_ptr;
    wr_ptr_next    = wr_ptr;
    count_next     = count;
    max_next       = max_count;
    in_ready_next  = in_ready;
    out_valid_next = out_valid;

    if (push) wr_ptr_next = (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
    if (pop)  rd_ptr_next = (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);

    count_next     = count + CW'(push) - CW'(pop);
    max_next       = (count_next > max_count) ? count_next : max_count;
    in_ready_next  = (count_next != CW'(DEPTH));
    out_valid_next = (count_next != '0);
  end

  // State registers; reset overrides any transfer in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= AW'(INIT_TOKENS % DEPTH);
      count     <= CW'(INIT_TOKENS);
      max_count <= CW'(INIT_TOKENS);
      in_ready  <= (INIT_TOKENS != DEPTH);
      out_valid <= (INIT_TOKENS != 0);
    end else begin
      rd_ptr    <= rd_ptr_next;
      wr_ptr    <= wr_ptr_next;
      count     <= count_next;
      max_count <= max_next;
      in_ready  <= in_ready_next;
      out_valid <= out_valid_next;
    end
  end

  bdf_channel_mem #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .INIT_TOKENS(INIT_TOKENS),
    .AW         (AW)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(in_data),
    .raddr(rd_ptr),
    .rdata(out_data)
  );

endmodule

// File: doc/bdf_channel.md
BDF_CHANNEL -- requirements
Module: bdf_channel

Interface
REQ-001 The module SHALL take parameter WIDTH, default 16, as the token data width in bits.
REQ-002 The module SHALL take parameter DEPTH, default 16, as the channel capacity in tokens; legal range is 2..256, and DEPTH need not be a power of two.
REQ-003 The module SHALL take parameter INIT_TOKENS, default 0, as the number of initial (delay) tokens on the edge; legal range is 0..DEPTH.
REQ-004 Port clk SHALL be an input, 1 bit wide, and the single clock; all logic is rising-edge.
REQ-005 Port rst SHALL be an input, 1 bit wide, and the reset; it is synchronous and active-low.
REQ-006 Port in_data SHALL be an input, WIDTH bits wide, carrying the token from the producer PE.
REQ-007 Port in_valid SHALL be an input, 1 bit wide, indicating the producer offers a token.
REQ-008 Port in_ready SHALL be an output, 1 bit wide, indicating the channel accepts a token this cycle.
REQ-009 Port out_data SHALL be an output, WIDTH bits wide, carrying the head token to the consumer PE.
REQ-010 Port out_valid SHALL be an output, 1 bit wide, indicating a head token is present.
REQ-011 Port out_ready SHALL be an input, 1 bit wide, indicating the consumer takes the head token.
REQ-012 Port count SHALL be an output, CW = $clog2(DEPTH+1) bits wide, giving current occupancy.
REQ-013 Port max_count SHALL be an output, CW bits wide, giving the high-water mark of occupancy since reset.

Function
REQ-014 A push SHALL occur on a cycle with in_valid && in_ready; a pop SHALL occur on a cycle with out_valid && out_ready.
REQ-015 in_ready SHALL equal (count != DEPTH); out_valid SHALL equal (count != 0); both SHALL be driven from registered state only, with no combinational path from in_valid or out_ready.
REQ-016 out_data SHALL present the head entry first-word-fall-through; its value is don't-care while out_valid is 0, but it SHALL be stable while out_valid && !out_ready.
REQ-017 Push-to-pop latency SHALL be 1 cycle: a token pushed into an empty channel in cycle N SHALL show out_valid=1 in cycle N+1, with no same-cycle bypass.
REQ-018 On a push, in_data SHALL be written at wr_ptr and wr_ptr SHALL advance; on a pop, rd_ptr SHALL advance; each pointer SHALL wrap from DEPTH-1 to 0.
REQ-019 When push and pop occur together, count SHALL be unchanged and both pointers SHALL advance.
REQ-020 When full, in_ready=0, so no push occurs even if a pop occurs that same cycle; in_ready returns to 1 in the next cycle.
REQ-021 When empty, no pop occurs regardless of out_ready, and a simultaneous push SHALL raise count to 1.
REQ-022 Token order SHALL be strictly FIFO, and no token SHALL be lost or duplicated.
REQ-023 max_count SHALL update to the next value of count whenever that value exceeds the current max_count.

Reset
REQ-024 While rst=0 at a clock edge: rd_ptr=0, wr_ptr=INIT_TOKENS mod DEPTH, count=INIT_TOKENS, max_count=INIT_TOKENS.
REQ-025 Storage entries 0..INIT_TOKENS-1 SHALL be cleared to 0 on reset; other entries need not be reset.
REQ-026 Reset asserted mid-transfer SHALL discard all in-flight tokens and override any push or pop in that cycle.
REQ-027 Outputs during and immediately after reset SHALL be in_ready=(INIT_TOKENS!=DEPTH) and out_valid=(INIT_TOKENS!=0).

Structure
REQ-028 defines_pkg SHALL hold the shared default data width constant and a channel-status struct typedef {count, max_count}.
REQ-029 An elaboration-time check SHALL fail the build when INIT_TOKENS > DEPTH or DEPTH < 2.
REQ-030 Storage SHALL be one sub-module, bdf_channel_mem, with 1 write port and 1 asynchronous read port; pointer and count logic SHALL stay in bdf_channel.

Verification
REQ-031 Scenario 1, reset preload: DEPTH=4, INIT_TOKENS=2, release reset, out_ready=1, no push -> two pops of 0x0000, then out_valid=0 and count=0.
REQ-032 Scenario 2, fill/drain: DEPTH=4, push 0x0001..0x0004 with out_ready=0 -> in_ready=0 and count=4; the 5th offer is not accepted; drain returns 1,2,3,4 in order.
REQ-033 Scenario 3, full with simultaneous pop: while full, assert in_valid and out_ready together -> pop of 0x0001 only; count=3 next cycle, and in_ready=1.
REQ-034 Scenario 4, empty with simultaneous push: from empty, push 0xBEEF with out_ready=1 -> no pop that cycle; out_valid=1 with out_data=0xBEEF next cycle.
REQ-035 Scenario 5, wrap and random: DEPTH=5, 1000 cycles of random valid/ready -> scoreboard order matches, and max_count never exceeds 5.
REQ-036 Scenario 6, mid-run reset: assert rst=0 with count=3 -> next cycle count=INIT_TOKENS and max_count=INIT_TOKENS; old tokens are never output.
